// File: rtl/sprite_slot_mux.sv
// Sprite slot engine and priority mux: per-slot X counters and pattern shifters feeding a lowest-index-wins pixel mux.
// Optional sprite-0 hit detection is built when SPRITE0_HIT_EN is defined; otherwise sprite0_hit is tied low.
module sprite_slot_mux #(
    parameter int SLOTS  = 8,
    parameter int SLOT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sprite_enabled,
    input  logic              no_sprite_clip,
    input  logic              first_column,
    input  logic              last_column,
    input  logic              pixel_tick,
    input  logic              line_clear,
    input  logic              load_en,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic [7:0]        load_x,
    input  logic [7:0]        load_lo,
    input  logic [7:0]        load_hi,
    input  logic [7:0]        load_attr,
    input  logic              load_s0,
    input  logic              bg_opaque,
    input  logic              hit_clear,
    output logic [3:0]        sprite_pixel,
    output logic              sprite_priority,
    output logic              pixel_valid,
    output logic              sprite0_hit
);

    logic [7:0] x_cnt [SLOTS];
    logic [7:0] sh_lo [SLOTS];
    logic [7:0] sh_hi [SLOTS];
    logic [1:0] pal   [SLOTS];
    logic       pri   [SLOTS];

    logic [7:0]       in_lo;
    logic [7:0]       in_hi;
    logic [SLOTS-1:0] load_sel;
    logic [SLOTS-1:0] slot_opaque;
    logic [3:0]       mux_pixel;
    logic             mux_priority;
    logic             clipped;
    logic             forced_clear;

    // Horizontal flip is applied once at load time so the shifter always emits from the MSB.
    always_comb begin
        in_lo = load_lo;
        in_hi = load_hi;
        if (load_attr[6]) begin
            for (int b = 0; b < 8; b++) begin
                in_lo[b] = load_lo[7-b];
                in_hi[b] = load_hi[7-b];
            end
        end
    end

    // Slot indices at or above SLOTS never match, so such loads are dropped.
    always_comb begin
        load_sel = '0;
        for (int i = 0; i < SLOTS; i++) begin
            load_sel[i] = load_en && (int'(load_slot) == i);
        end
    end

    always_comb begin
        slot_opaque = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_opaque[i] = (x_cnt[i] == 8'd0) && (sh_hi[i][7] || sh_lo[i][7]);
        end
    end

    // Scanning from the highest index down lets the lowest opaque slot win.
    always_comb begin
        mux_pixel    = 4'd0;
        mux_priority = 1'b1;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_opaque[i]) begin
                mux_pixel    = {pal[i], sh_hi[i][7], sh_lo[i][7]};
                mux_priority = pri[i];
            end
        end
    end

    assign clipped      = ~no_sprite_clip & first_column;
    assign forced_clear = ~sprite_enabled | clipped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                x_cnt[i] <= 8'd0;
                sh_lo[i] <= 8'd0;
                sh_hi[i] <= 8'd0;
                pal[i]   <= 2'd0;
                pri[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (load_sel[i]) begin
                    x_cnt[i] <= load_x;
                    sh_lo[i] <= in_lo;
                    sh_hi[i] <= in_hi;
                    pal[i]   <= load_attr[1:0];
                    pri[i]   <= load_attr[5];
                end else begin
                    if (pixel_tick && (x_cnt[i] != 8'd0)) begin
                        x_cnt[i] <= x_cnt[i] - 8'd1;
                    end
                    if (line_clear) begin
                        sh_lo[i] <= 8'd0;
                        sh_hi[i] <= 8'd0;
                    end else if (pixel_tick && (x_cnt[i] == 8'd0)) begin
                        sh_lo[i] <= {sh_lo[i][6:0], 1'b0};
                        sh_hi[i] <= {sh_hi[i][6:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sprite_pixel    <= 4'd0;
            sprite_priority <= 1'b1;
            pixel_valid     <= 1'b0;
        end else if (pixel_tick) begin
            pixel_valid <= 1'b1;
            if (forced_clear) begin
                sprite_pixel    <= 4'd0;
                sprite_priority <= 1'b1;
            end else begin
                sprite_pixel    <= mux_pixel;
                sprite_priority <= mux_priority;
            end
        end else begin
            pixel_valid <= 1'b0;
        end
    end

`ifdef SPRITE0_HIT_EN
    logic s0_valid;
    logic hit_set;
    logic unused_attr;

    assign unused_attr = ^{load_attr[7], load_attr[4:2]};
    assign hit_set = pixel_tick & s0_valid & slot_opaque[0] & bg_opaque
                   & ~forced_clear & ~last_column;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
        end else if (load_sel[0]) begin
            s0_valid <= load_s0;
        end else if (line_clear) begin
            s0_valid <= 1'b0;
        end
    end

    // A clear in the same cycle as a hit wins, so software never sees a stale flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sprite0_hit <= 1'b0;
        end else if (hit_clear) begin
            sprite0_hit <= 1'b0;
        end else if (hit_set) begin
            sprite0_hit <= 1'b1;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{load_attr[7], load_attr[4:2], load_s0, bg_opaque,
                             last_column, hit_clear};
    assign sprite0_hit   = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_slot_mux.sv
// Self-checking bench for sprite_slot_mux: directed scenarios plus random traffic against a
// sprite-position reference model (pixel = pattern column (ticks - x) of the loaded sprite).
module tb_sprite_slot_mux;

    localparam int SLOTS  = 6;
    localparam int SLOT_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              sprite_enabled, no_sprite_clip, first_column, last_column;
    logic              pixel_tick, line_clear, load_en;
    logic [SLOT_W-1:0] load_slot;
    logic [7:0]        load_x, load_lo, load_hi, load_attr;
    logic              load_s0, bg_opaque, hit_clear;
    logic [3:0]        sprite_pixel;
    logic              sprite_priority, pixel_valid, sprite0_hit;

    always #5 clk = ~clk;

    sprite_slot_mux #(.SLOTS(SLOTS), .SLOT_W(SLOT_W)) dut (
        .clk(clk), .rst(rst),
        .sprite_enabled(sprite_enabled), .no_sprite_clip(no_sprite_clip),
        .first_column(first_column), .last_column(last_column),
        .pixel_tick(pixel_tick), .line_clear(line_clear),
        .load_en(load_en), .load_slot(load_slot), .load_x(load_x),
        .load_lo(load_lo), .load_hi(load_hi), .load_attr(load_attr),
        .load_s0(load_s0), .bg_opaque(bg_opaque), .hit_clear(hit_clear),
        .sprite_pixel(sprite_pixel), .sprite_priority(sprite_priority),
        .pixel_valid(pixel_valid), .sprite0_hit(sprite0_hit)
    );

    // Reference model: each slot remembers the sprite as loaded and how many ticks have passed.
    int         m_x    [SLOTS];
    int         m_t    [SLOTS];
    logic [7:0] m_lo   [SLOTS];
    logic [7:0] m_hi   [SLOTS];
    logic       m_flip [SLOTS];
    logic [1:0] m_pal  [SLOTS];
    logic       m_pri  [SLOTS];
    logic       m_clr  [SLOTS];
    logic       m_s0;
    logic [3:0] exp_pix;
    logic       exp_pri, exp_valid, exp_hit;

    int checks   = 0;
    int failures = 0;

    localparam logic HIT_ON =
`ifdef SPRITE0_HIT_EN
        1'b1;
`else
        1'b0;
`endif

    function automatic logic [3:0] slot_pix(int s);
        int c, b;
        if (m_clr[s] || m_t[s] < m_x[s]) return 4'd0;
        c = m_t[s] - m_x[s];
        if (c >= 8) return 4'd0;
        b = m_flip[s] ? c : 7 - c;
        if (!m_lo[s][b] && !m_hi[s][b]) return 4'd0;
        return {m_pal[s], m_hi[s][b], m_lo[s][b]};
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_output();
        check_eq("pixel", {4'd0, sprite_pixel}, {4'd0, exp_pix});
        check_eq("priority", {7'd0, sprite_priority}, {7'd0, exp_pri});
        check_eq("valid", {7'd0, pixel_valid}, {7'd0, exp_valid});
        check_eq("hit", {7'd0, sprite0_hit}, {7'd0, exp_hit});
    endtask

    task automatic model_reset();
        for (int s = 0; s < SLOTS; s++) begin
            m_x[s] = 0; m_t[s] = 0; m_lo[s] = 0; m_hi[s] = 0;
            m_flip[s] = 0; m_pal[s] = 0; m_pri[s] = 0; m_clr[s] = 1;
        end
        m_s0 = 0; exp_pix = 0; exp_pri = 1; exp_valid = 0; exp_hit = 0;
    endtask

    // One clock: predict from pre-edge state and current inputs, clock, update model, compare.
    task automatic apply_stimulus();
        logic [3:0] w_pix, p;
        logic       w_pri, forced, cond;
        w_pix = 4'd0; w_pri = 1'b1;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            p = slot_pix(s);
            if (p[1:0] != 2'd0) begin w_pix = p; w_pri = m_pri[s]; end
        end
        forced = !sprite_enabled || (!no_sprite_clip && first_column);
        p = slot_pix(0);
        cond = m_s0 && (p[1:0] != 2'd0) && bg_opaque && !forced && !last_column;
        @(posedge clk);
        #1;
        if (pixel_tick) begin
            exp_valid = 1;
            exp_pix = forced ? 4'd0 : w_pix;
            exp_pri = forced ? 1'b1 : w_pri;
        end else begin
            exp_valid = 0;
        end
        if (HIT_ON) begin
            if (hit_clear) exp_hit = 0;
            else if (pixel_tick && cond) exp_hit = 1;
        end
        for (int s = 0; s < SLOTS; s++) begin
            if (load_en && int'(load_slot) == s) begin
                m_x[s] = int'(load_x); m_t[s] = 0; m_lo[s] = load_lo; m_hi[s] = load_hi;
                m_flip[s] = load_attr[6]; m_pal[s] = load_attr[1:0]; m_pri[s] = load_attr[5];
                m_clr[s] = 0;
                if (s == 0) m_s0 = load_s0;
            end else begin
                if (pixel_tick) m_t[s]++;
                if (line_clear) begin
                    m_clr[s] = 1;
                    if (s == 0) m_s0 = 0;
                end
            end
        end
        check_output();
    endtask

    task automatic load(input int slot, input int x, input logic [7:0] lo, input logic [7:0] hi,
                        input logic [7:0] attr, input logic s0);
        load_en = 1; load_slot = SLOT_W'(slot); load_x = 8'(x);
        load_lo = lo; load_hi = hi; load_attr = attr; load_s0 = s0;
        apply_stimulus();
        load_en = 0; load_s0 = 0;
    endtask

    task automatic tick(input int n);
        pixel_tick = 1;
        repeat (n) apply_stimulus();
        pixel_tick = 0;
    endtask

    task automatic clear_line();
        line_clear = 1;
        apply_stimulus();
        line_clear = 0;
    endtask

    initial begin
        rst = 1; sprite_enabled = 1; no_sprite_clip = 1; first_column = 0; last_column = 0;
        pixel_tick = 0; line_clear = 0; load_en = 0; load_slot = 0; load_x = 0;
        load_lo = 0; load_hi = 0; load_attr = 0; load_s0 = 0; bg_opaque = 0; hit_clear = 0;
        model_reset();
        #3;
        check_output();
        @(posedge clk); #1;
        rst = 0;
        check_output();

        $display("[TB] slot 2 at x=3");
        load(2, 3, 8'h80, 8'h00, 8'h01, 0);
        tick(3);
        tick(1);
        check_eq("tp_x3_pixel", {4'd0, sprite_pixel}, 8'h05);
        check_eq("tp_x3_pri", {7'd0, sprite_priority}, 8'h00);
        tick(1);
        check_eq("tp_x3_after", {4'd0, sprite_pixel}, 8'h00);

        $display("[TB] slot priority 1 vs 5");
        clear_line();
        load(1, 0, 8'hFF, 8'h00, 8'h02, 0);
        load(5, 0, 8'hFF, 8'hFF, 8'h23, 0);
        tick(1);
        check_eq("tp_low_wins", {4'd0, sprite_pixel}, 8'h09);
        load(1, 0, 8'h00, 8'h00, 8'h02, 0);
        tick(1);
        check_eq("tp_slot5", {4'd0, sprite_pixel}, 8'h0F);
        check_eq("tp_slot5_pri", {7'd0, sprite_priority}, 8'h01);

        $display("[TB] horizontal flip and ignored slot index");
        clear_line();
        load(3, 0, 8'h01, 8'h01, 8'h41, 0);
        load(7, 0, 8'hFF, 8'hFF, 8'h03, 0);
        tick(1);
        check_eq("tp_flip", {4'd0, sprite_pixel}, 8'h07);
        tick(7);
        check_eq("tp_flip_end", {4'd0, sprite_pixel}, 8'h00);

        $display("[TB] left-column clip and sprite-0 hit");
        clear_line();
        load(0, 0, 8'hFF, 8'h00, 8'h00, 1);
        bg_opaque = 1; no_sprite_clip = 0; first_column = 1;
        tick(1);
        check_eq("tp_clip_pix", {4'd0, sprite_pixel}, 8'h00);
        check_eq("tp_clip_pri", {7'd0, sprite_priority}, 8'h01);
        first_column = 0;
        tick(1);
        check_eq("tp_unclip", {4'd0, sprite_pixel}, 8'h01);
        check_eq("tp_hit", {7'd0, sprite0_hit}, {7'd0, HIT_ON});
        hit_clear = 1; apply_stimulus(); hit_clear = 0;
        check_eq("tp_hit_clear", {7'd0, sprite0_hit}, 8'h00);
        last_column = 1;
        tick(1);
        check_eq("tp_last_col", {7'd0, sprite0_hit}, 8'h00);
        last_column = 0; hit_clear = 1;
        tick(1);
        check_eq("tp_clear_wins", {7'd0, sprite0_hit}, 8'h00);
        hit_clear = 0;
        tick(1);
        check_eq("tp_hit_again", {7'd0, sprite0_hit}, {7'd0, HIT_ON});
        no_sprite_clip = 1; bg_opaque = 0;

        $display("[TB] random traffic");
        for (int n = 0; n < 1500; n++) begin
            pixel_tick     = ($urandom_range(0, 9) < 7);
            load_en        = ($urandom_range(0, 5) == 0);
            load_slot      = SLOT_W'($urandom_range(0, 7));
            load_x         = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            load_lo        = 8'($urandom);
            load_hi        = 8'($urandom);
            load_attr      = 8'($urandom);
            load_s0        = 1'($urandom);
            line_clear     = ($urandom_range(0, 59) == 0);
            hit_clear      = ($urandom_range(0, 29) == 0);
            sprite_enabled = ($urandom_range(0, 15) != 0);
            no_sprite_clip = 1'($urandom);
            first_column   = ($urandom_range(0, 3) == 0);
            last_column    = ($urandom_range(0, 7) == 0);
            bg_opaque      = 1'($urandom);
            apply_stimulus();
        end
        pixel_tick = 0; load_en = 0; line_clear = 0; hit_clear = 0; load_s0 = 0;
        sprite_enabled = 1; no_sprite_clip = 1; first_column = 0; last_column = 0; bg_opaque = 1;

        $display("[TB] asynchronous reset mid-line");
        clear_line();
        load(0, 0, 8'hFF, 8'hFF, 8'h03, 1);
        tick(2);
        #2 rst = 1;
        #1;
        model_reset();
        check_output();
        @(posedge clk); #1;
        rst = 0;
        tick(4);
        check_eq("tp_post_reset", {4'd0, sprite_pixel}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
